// File: rtl/ddr_readback_pkg.sv
// ddr_readback_pkg: shared defaults, FSM encoding and helpers for the DDR
// read-data return path (ddr_readback and its rb_fifo buffer).
//   RB_DEPTH_DEF   - default read-data FIFO depth in 512-bit beats
//   TMO_CYCLES_DEF - default idle cycles with reads pending before timeout
//   TMO_W          - width of the timeout counter
//   BEAT_W         - read-data beat width
//   rb_state_e     - readback FSM state encoding
package ddr_readback_pkg;

    localparam int RB_DEPTH_DEF   = 16;
    localparam int TMO_CYCLES_DEF = 4096;
    localparam int TMO_W          = 12;
    localparam int BEAT_W         = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } rb_state_e;

    // Number of read-issue strobes asserted in one cycle (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/ddr_readback_rb_fifo.sv
// rb_fifo: first-word-fall-through synchronous FIFO for read-data beats.
// A beat pushed in cycle N is visible at rdata_o/valid_o in cycle N+1.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   flush_i      - empty the FIFO next cycle (pointers and level to 0)
//   push_i       - write wdata_i (accepted when not full, or when popping)
//   pop_i        - consume the head (ignored when empty)
//   wdata_i      - beat to write
//   rdata_o      - head data, 0 when empty
//   valid_o      - head valid (level != 0)
//   full_o       - level == DEPTH
//   level_o      - occupancy
module rb_fifo
    import ddr_readback_pkg::*;
#(
    parameter int DEPTH = RB_DEPTH_DEF,
    parameter int W     = BEAT_W,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          valid_o,
    output logic          full_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          do_push;
    logic          do_pop;

    assign valid_o = (level_q != '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign level_o = level_q;
    // Head is forced to zero when empty so the output is defined after reset.
    assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;

    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointers wrap naturally: DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ddr_readback.sv
// ddr_readback: tracks outstanding DDR reads, buffers returned beats in a
// FWFT FIFO toward the host, and flags protocol errors.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   ddr_read[3:0]   - per-slot read-issue strobes
//   rd_valid/rd_data- read-data beat from the DDR IP (no backpressure)
//   rb_valid/rb_data- FIFO head toward host, rb_ready accepts it
//   flush           - discard buffered data and pending state
//   err_clr         - clear the sticky error flags
//   rb_level        - FIFO occupancy
//   pending         - reads issued but not yet returned
//   idle            - FSM in IDLE and FIFO empty
//   err_ovf/err_unexp/err_tmo/err_pend - sticky error flags
module ddr_readback
    import ddr_readback_pkg::*;
#(
    parameter int RB_DEPTH   = RB_DEPTH_DEF,
    parameter int PEND_W     = 10,
    parameter int TMO_CYCLES = TMO_CYCLES_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                ddr_read,
    input  logic                      rd_valid,
    input  logic [BEAT_W-1:0]         rd_data,
    output logic                      rb_valid,
    output logic [BEAT_W-1:0]         rb_data,
    input  logic                      rb_ready,
    input  logic                      flush,
    input  logic                      err_clr,
    output logic [$clog2(RB_DEPTH):0] rb_level,
    output logic [PEND_W-1:0]         pending,
    output logic                      idle,
    output logic                      err_ovf,
    output logic                      err_unexp,
    output logic                      err_tmo,
    output logic                      err_pend
);

    localparam int SW = PEND_W + 3;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    rb_state_e         state_q;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;
    logic [TMO_W-1:0]  timer_q;
    logic              err_ovf_q, err_unexp_q, err_tmo_q, err_pend_q;

    logic              pop;
    logic              push;
    logic              full;
    logic              has_pend;
    logic              ovf_ev, unexp_ev, tmo_ev, pend_ev;
    logic [SW-1:0]     pend_add;
    logic [SW-1:0]     pend_dec;
    logic [SW-1:0]     pend_diff;

    assign pop      = rb_valid && rb_ready;
    assign has_pend = (pending_q != '0);
    assign push     = rd_valid && has_pend && (!full || pop) && !flush;

    always_comb begin
        ovf_ev   = rd_valid && has_pend && full && !pop;
        // A beat with nothing outstanding is dropped and does not count down.
        unexp_ev = rd_valid && !has_pend;
        tmo_ev   = (state_q == ST_WAIT) && !rd_valid && (timer_q == TMO_LAST);

        pend_add  = SW'(pending_q) + SW'(popcount4(ddr_read));
        pend_dec  = SW'(rd_valid && has_pend);
        pend_diff = (pend_add < pend_dec) ? '0 : (pend_add - pend_dec);
        pend_ev   = (pend_diff > SW'(PEND_MAX));
        pending_d = pend_ev ? PEND_MAX : pend_diff[PEND_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            timer_q     <= '0;
            err_ovf_q   <= 1'b0;
            err_unexp_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_pend_q  <= 1'b0;
        end else if (flush) begin
            // Flush drops this cycle's strobes and beats; error flags hold.
            state_q   <= ST_IDLE;
            pending_q <= '0;
            timer_q   <= '0;
        end else begin
            err_ovf_q   <= (err_ovf_q   && !err_clr) || ovf_ev;
            err_unexp_q <= (err_unexp_q && !err_clr) || unexp_ev;
            err_tmo_q   <= (err_tmo_q   && !err_clr) || tmo_ev;
            err_pend_q  <= (err_pend_q  && !err_clr) || pend_ev;

            if (tmo_ev) begin
                // Give up on the outstanding reads; buffered beats stay.
                state_q   <= ST_IDLE;
                pending_q <= '0;
                timer_q   <= '0;
            end else begin
                pending_q <= pending_d;
                state_q   <= (pending_d != '0) ? ST_WAIT : ST_IDLE;
                // Held at zero in IDLE, so entry to WAIT starts from zero.
                if (state_q == ST_IDLE || rd_valid) timer_q <= '0;
                else                                timer_q <= timer_q + 1'b1;
            end
        end
    end

    rb_fifo #(
        .DEPTH (RB_DEPTH),
        .W     (BEAT_W)
    ) u_rb_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (rd_data),
        .rdata_o (rb_data),
        .valid_o (rb_valid),
        .full_o  (full),
        .level_o (rb_level)
    );

    assign pending   = pending_q;
    assign idle      = (state_q == ST_IDLE) && (rb_level == '0);
    assign err_ovf   = err_ovf_q;
    assign err_unexp = err_unexp_q;
    assign err_tmo   = err_tmo_q;
    assign err_pend  = err_pend_q;

endmodule

// File: tb/tb_ddr_readback.sv
// tb_ddr_readback: directed table vectors plus hand-written multi-cycle
// sequences for ddr_readback (default parameters).
module tb_ddr_readback;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ddr_read;
    logic         rd_valid;
    logic [511:0] rd_data;
    logic         rb_valid;
    logic [511:0] rb_data;
    logic         rb_ready;
    logic         flush;
    logic         err_clr;
    logic [4:0]   rb_level;
    logic [9:0]   pending;
    logic         idle;
    logic         err_ovf, err_unexp, err_tmo, err_pend;

    int errors = 0;
    int checks = 0;

    ddr_readback #(
        .RB_DEPTH   (16),
        .PEND_W     (10),
        .TMO_CYCLES (4096)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ddr_read  (ddr_read),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rb_valid  (rb_valid),
        .rb_data   (rb_data),
        .rb_ready  (rb_ready),
        .flush     (flush),
        .err_clr   (err_clr),
        .rb_level  (rb_level),
        .pending   (pending),
        .idle      (idle),
        .err_ovf   (err_ovf),
        .err_unexp (err_unexp),
        .err_tmo   (err_tmo),
        .err_pend  (err_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        logic       rv;
        logic [7:0] d;
        logic       rdy;
        logic       fl;
        logic       ec;
        logic [9:0] e_pend;
        logic [4:0] e_lvl;
        logic       e_val;
        logic [7:0] e_dat;
        logic       e_idle;
        logic [3:0] e_err;   // {ovf, unexp, tmo, pend}
    } vec_t;

    vec_t vecs [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(i);
        return {16{w}};
    endfunction

    task automatic quiet();
        ddr_read = '0;
        rd_valid = 1'b0;
        rd_data  = '0;
        rb_ready = 1'b0;
        flush    = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".rb_valid"}, 512'(rb_valid), 512'(0));
        check({tag, ".rb_data"},  rb_data, '0);
        check({tag, ".rb_level"}, 512'(rb_level), 512'(0));
        check({tag, ".pending"},  512'(pending), 512'(0));
        check({tag, ".idle"},     512'(idle), 512'(1));
        check({tag, ".errs"},     512'({err_ovf, err_unexp, err_tmo, err_pend}), 512'(0));
    endtask

    initial begin
        int n;
        logic [7:0] b;

        rst = 1'b1;
        quiet();
        do_reset();
        check_reset_state("reset");

        //            rd      rv    d      rdy   fl    ec    pend    lvl   val   dat    idle  err
        vecs[0]  = '{4'b1011, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'd3, 5'd0, 1'b0, 8'h00, 1'b0, 4'b0000};
        vecs[1]  = '{4'b0000, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 10'd2, 5'd1, 1'b1, 8'h11, 1'b0, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 10'd1, 5'd1, 1'b1, 8'h22, 1'b0, 4'b0000};
        vecs[3]  = '{4'b0000, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 10'd0, 5'd1, 1'b1, 8'h33, 1'b0, 4'b0000};
        vecs[4]  = '{4'b0000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0000};
        vecs[5]  = '{4'b0000, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0100};
        vecs[6]  = '{4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0000};
        vecs[7]  = '{4'b0000, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0100};
        vecs[8]  = '{4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0000};
        vecs[9]  = '{4'b1111, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 10'd4, 5'd0, 1'b0, 8'h00, 1'b0, 4'b0100};
        vecs[10] = '{4'b1111, 1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0100};
        vecs[11] = '{4'b0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 10'd0, 5'd0, 1'b0, 8'h00, 1'b1, 4'b0000};

        for (int i = 0; i < 12; i++) begin
            ddr_read = vecs[i].rd;
            rd_valid = vecs[i].rv;
            b        = vecs[i].d;
            rd_data  = {64{b}};
            rb_ready = vecs[i].rdy;
            flush    = vecs[i].fl;
            err_clr  = vecs[i].ec;
            tick();
            b = vecs[i].e_dat;
            check($sformatf("v%0d.pending", i),  512'(pending),  512'(vecs[i].e_pend));
            check($sformatf("v%0d.rb_level", i), 512'(rb_level), 512'(vecs[i].e_lvl));
            check($sformatf("v%0d.rb_valid", i), 512'(rb_valid), 512'(vecs[i].e_val));
            check($sformatf("v%0d.rb_data", i),  rb_data, {64{b}});
            check($sformatf("v%0d.idle", i),     512'(idle),     512'(vecs[i].e_idle));
            check($sformatf("v%0d.errs", i),
                  512'({err_ovf, err_unexp, err_tmo, err_pend}), 512'(vecs[i].e_err));
        end
        quiet();

        // Full and overflow: 17 reads, 17 beats with no host acceptance.
        do_reset();
        ddr_read = 4'b1111;
        repeat (4) tick();
        ddr_read = 4'b0001;
        tick();
        ddr_read = '0;
        check("ovf.pending17", 512'(pending), 512'(17));
        rd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_data = pat(i);
            tick();
        end
        check("ovf.level16", 512'(rb_level), 512'(16));
        check("ovf.no_err_yet", 512'(err_ovf), 512'(0));
        rd_data = pat(16);
        tick();
        rd_valid = 1'b0;
        check("ovf.level", 512'(rb_level), 512'(16));
        check("ovf.err_ovf", 512'(err_ovf), 512'(1));
        check("ovf.pending", 512'(pending), 512'(0));
        rb_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (!rb_valid) break;
            check($sformatf("ovf.drain%0d", n), rb_data, pat(n));
            n++;
            tick();
        end
        check("ovf.drain_count", 512'(n), 512'(16));
        check("ovf.empty", 512'(rb_level), 512'(0));
        quiet();

        // Full with same-cycle push and pop.
        do_reset();
        ddr_read = 4'b1111;
        repeat (4) tick();
        ddr_read = 4'b0001;
        tick();
        ddr_read = '0;
        rd_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rd_data = pat(i);
            tick();
        end
        check("pp.level_before", 512'(rb_level), 512'(16));
        rd_data  = pat(16);
        rb_ready = 1'b1;
        tick();
        quiet();
        check("pp.level", 512'(rb_level), 512'(16));
        check("pp.err_ovf", 512'(err_ovf), 512'(0));
        check("pp.pending", 512'(pending), 512'(0));
        check("pp.head", rb_data, pat(1));

        // Timeout then flush.
        do_reset();
        ddr_read = 4'b0011;
        tick();
        ddr_read = '0;
        rd_valid = 1'b1;
        rd_data  = pat(7);
        tick();
        rd_valid = 1'b0;
        check("tmo.pending1", 512'(pending), 512'(1));
        n = 0;
        while (!err_tmo && n < 5000) begin
            tick();
            n++;
        end
        check("tmo.cycles", 512'(n), 512'(4096));
        check("tmo.err_tmo", 512'(err_tmo), 512'(1));
        check("tmo.pending", 512'(pending), 512'(0));
        check("tmo.level", 512'(rb_level), 512'(1));
        check("tmo.head", rb_data, pat(7));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush.level", 512'(rb_level), 512'(0));
        check("flush.err_tmo", 512'(err_tmo), 512'(1));
        check("flush.idle", 512'(idle), 512'(1));

        // Pending counter saturation.
        do_reset();
        ddr_read = 4'b1111;
        repeat (255) tick();
        check("sat.pending1020", 512'(pending), 512'(1020));
        check("sat.no_err", 512'(err_pend), 512'(0));
        tick();
        check("sat.pending_max", 512'(pending), 512'(1023));
        check("sat.err_pend", 512'(err_pend), 512'(1));
        ddr_read = '0;

        // Reset mid-stream: 5 beats buffered, 3 reads outstanding.
        do_reset();
        ddr_read = 4'b1111;
        repeat (2) tick();
        ddr_read = '0;
        rd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rd_data = pat(20 + i);
            tick();
        end
        check("mid.level5", 512'(rb_level), 512'(5));
        check("mid.pending3", 512'(pending), 512'(3));
        rst      = 1'b1;
        ddr_read = 4'b1111;
        rd_data  = pat(30);
        tick();
        rst = 1'b0;
        quiet();
        check_reset_state("mid_rst");
        rd_valid = 1'b1;
        rd_data  = pat(31);
        tick();
        rd_valid = 1'b0;
        check("mid.err_unexp", 512'(err_unexp), 512'(1));
        check("mid.level0", 512'(rb_level), 512'(0));
        check("mid.pending0", 512'(pending), 512'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_readback.md
DDR_READBACK -- requirements
Module: ddr_readback

Interface
REQ-001 Parameter RB_DEPTH, 16, read-data FIFO depth in 512-bit beats (power of two, 4..64).
REQ-002 Parameter PEND_W, 10, width of the outstanding-read counter.
REQ-003 Parameter TMO_CYCLES, 4096, idle cycles with reads pending before a timeout fires.
REQ-004 clk  in  1  clock; all logic is on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 ddr_read  in  4  per-slot read-issue strobes, the registered command strobes driven to the DDRX IP.
REQ-007 rd_valid  in  1  read-data beat valid from the DDRX IP; no backpressure toward the IP.
REQ-008 rd_data  in  512  read-data beat.
REQ-009 rb_valid  out  1  FIFO head valid toward the host path.
REQ-010 rb_data  out  512  FIFO head data.
REQ-011 rb_ready  in  1  host accepts the head.
REQ-012 flush  in  1  discard all buffered data and pending state.
REQ-013 err_clr  in  1  clear the sticky error flags.
REQ-014 rb_level  out  $clog2(RB_DEPTH)+1  FIFO occupancy.
REQ-015 pending  out  PEND_W  outstanding reads, issued but not yet returned.
REQ-016 idle  out  1  high when the FSM is in IDLE and the FIFO is empty.
REQ-017 err_ovf, err_unexp, err_tmo, err_pend  out  1 each  sticky error flags.

Function
REQ-018 pending' = pending + popcount(ddr_read) - (rd_valid ? 1 : 0), computed in PEND_W+3 bits. The result saturates to 0 and to 2^PEND_W-1. Saturation at the top sets err_pend.
REQ-019 Push condition: rd_valid && pending>0 && (level<RB_DEPTH || pop).
- Pop is rb_valid && rb_ready.
- Simultaneous push and pop when full is accepted, and the level is unchanged.
REQ-020 A beat arriving when rd_valid && pending==0 is dropped and sets err_unexp. That beat does not change pending.
REQ-021 A beat arriving when rd_valid && pending>0 && full && !pop is dropped and sets err_ovf. Pending still decrements.
REQ-022 FIFO head is first-word-fall-through.
- A beat pushed in cycle N drives rb_valid=1 and rb_data in cycle N+1 (1-cycle latency).
- rb_valid = (rb_level != 0).
REQ-023 Data order is preserved. The FIFO pointers wrap modulo RB_DEPTH.
REQ-024 rb_data holds its value while rb_valid && !rb_ready.
REQ-025 The FSM has two states: IDLE and WAIT.
- IDLE -> WAIT when pending' > 0.
- WAIT -> IDLE when pending' == 0.
- WAIT -> IDLE on timeout.
REQ-026 The 12-bit timeout counter behaves as follows:
- It clears on entry to WAIT and on every rd_valid.
- It increments each cycle in WAIT without rd_valid.
- When it reaches TMO_CYCLES-1 it sets err_tmo, forces pending to 0 and goes to IDLE.
- FIFO contents are retained on timeout.
REQ-027 flush has priority over all other inputs that cycle.
- The next cycle has FIFO empty, pending=0, timer=0 and state IDLE.
- Same-cycle ddr_read strobes and rd_valid beats are ignored.
- Error flags are unchanged.
REQ-028 err_clr clears all four flags next cycle. An error event in the same cycle wins, and that flag is set.
REQ-029 idle = (state==IDLE) && rb_level==0.

Reset
REQ-030 On rst:
- rb_valid=0, rb_data=0, rb_level=0, pending=0.
- FIFO pointers=0, timer=0, state=IDLE, idle=1.
- All err_* = 0.
REQ-031 rst mid-operation discards buffered beats and pending count immediately, with no drain. Inputs are ignored while rst is high.

Structure
REQ-032 RB_DEPTH default, TMO_CYCLES default and the FSM state encoding live in the shared parameters/encoding headers.
REQ-033 The FIFO storage and pointer logic is one sub-module, rb_fifo (FWFT, synchronous, flush port), instantiated once. The counter, timer, FSM and error logic live in ddr_readback.

Verification
REQ-034 Pending and ordering: ddr_read=4'b1011 in cycle 0, then 3 rd_valid beats D0..D2 with rb_ready=1.
- pending goes 3, then 2, 1, 0.
- rb_data returns D0, D1, D2 in order, each 1 cycle after its beat.
- idle=1 at the end.
REQ-035 Full and overflow: issue 17 reads, hold rb_ready=0, deliver 17 beats.
- rb_level=16 and err_ovf=1.
- The 17th beat is lost and pending=0.
- Asserting rb_ready drains exactly 16 beats.
REQ-036 Full with same-cycle push and pop: at level 16 with rb_ready=1, deliver a beat.
- Push is accepted, rb_level stays 16, err_ovf stays 0.
REQ-037 Unexpected beat: with pending=0, drive rd_valid with data 0xA5.
- err_unexp=1, rb_level=0, pending=0.
- err_clr then gives err_unexp=0.
REQ-038 Timeout and flush:
- Issue 2 reads, return 1 beat, then go silent for 4096 cycles: err_tmo=1, pending=0, state IDLE, 1 beat still buffered.
- Then flush: rb_level=0 next cycle and err_tmo stays 1.
REQ-039 Reset mid-stream: with 5 beats buffered and pending=3, assert rst for 1 cycle.
- All outputs match REQ-030 the next cycle.
- A later beat sets err_unexp.
